// File: rtl/alu_exec_unit_if.sv
// Valid/ready bundle between the operand mux, the execute ALU and its consumers.
// The master drives operations and accepts results; the slave is the ALU.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_overflow;
  logic             flag_sign;

  modport master (
    output in_valid, alu_sel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_carry, flag_overflow, flag_sign
  );

  modport slave (
    input  in_valid, alu_sel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_carry, flag_overflow, flag_sign
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, bit-serial shifts,
// valid/ready on both sides, result held with Z/C/V/N flags until drained.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus,
  output logic           busy
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned SUM_W   = WIDTH + 1;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_LUI  = 4'b0011;
  localparam logic [3:0] SEL_OR   = 4'b0100;
  localparam logic [3:0] SEL_AND  = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0111;
  localparam logic [3:0] SEL_SRL  = 4'b1000;
  localparam logic [3:0] SEL_SLL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
  localparam logic [3:0] SEL_SLT  = 4'b1101;
  localparam logic [3:0] SEL_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [3:0]         sel_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   work_q;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   comb_res;
  logic               comb_c;
  logic               comb_v;
  logic [WIDTH-1:0]   shift_nxt;

  // Single-cycle datapath evaluated on the presented operands; a zero-amount shift passes A.
  always_comb begin : alu_comb
    shamt    = bus.op_b[SHAMT_W-1:0];
    is_shift = (bus.alu_sel == SEL_SRL) || (bus.alu_sel == SEL_SLL) || (bus.alu_sel == SEL_SRA);
    b_eff    = (bus.alu_sel == SEL_SUB) ? ~bus.op_b : bus.op_b;
    sum      = {1'b0, bus.op_a} + {1'b0, b_eff} + SUM_W'(bus.alu_sel == SEL_SUB);
    comb_res = '0;
    comb_c   = 1'b0;
    comb_v   = 1'b0;
    case (bus.alu_sel)
      SEL_ADD, SEL_SUB: begin
        comb_res = sum[WIDTH-1:0];
        comb_c   = sum[WIDTH];
        comb_v   = (bus.op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      SEL_LUI:                   comb_res = bus.op_b;
      SEL_OR:                    comb_res = bus.op_a | bus.op_b;
      SEL_AND:                   comb_res = bus.op_a & bus.op_b;
      SEL_XOR:                   comb_res = bus.op_a ^ bus.op_b;
      SEL_SRL, SEL_SLL, SEL_SRA: comb_res = bus.op_a;
      SEL_SLT:                   comb_res = WIDTH'($signed(bus.op_a) < $signed(bus.op_b));
      SEL_SLTU:                  comb_res = WIDTH'(bus.op_a < bus.op_b);
      default:                   comb_res = '0;
    endcase
  end

  // One-bit shift step applied to the working register each SHIFT cycle.
  always_comb begin : shift_step
    shift_nxt = work_q;
    case (sel_q)
      SEL_SRL: shift_nxt = {1'b0, work_q[WIDTH-1:1]};
      SEL_SLL: shift_nxt = {work_q[WIDTH-2:0], 1'b0};
      SEL_SRA: shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_nxt = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      sel_q             <= '0;
      cnt_q             <= '0;
      work_q            <= '0;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.result        <= '0;
      bus.flag_zero     <= 1'b0;
      bus.flag_carry    <= 1'b0;
      bus.flag_overflow <= 1'b0;
      bus.flag_sign     <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            sel_q        <= bus.alu_sel;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            if (is_shift && (shamt != '0)) begin
              state  <= SHIFT;
              cnt_q  <= shamt;
              work_q <= bus.op_a;
            end else begin
              state             <= DONE;
              bus.out_valid     <= 1'b1;
              bus.result        <= comb_res;
              bus.flag_zero     <= (comb_res == '0);
              bus.flag_carry    <= comb_c;
              bus.flag_overflow <= comb_v;
              bus.flag_sign     <= comb_res[WIDTH-1];
            end
          end
        end
        SHIFT: begin
          work_q <= shift_nxt;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          // Final step: the last shifted value is the result.
          if (cnt_q == SHAMT_W'(1)) begin
            state             <= DONE;
            bus.out_valid     <= 1'b1;
            bus.result        <= shift_nxt;
            bus.flag_zero     <= (shift_nxt == '0);
            bus.flag_carry    <= 1'b0;
            bus.flag_overflow <= 1'b0;
            bus.flag_sign     <= shift_nxt[WIDTH-1];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit_if #(.WIDTH(32)) bif ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    longint sa;
    longint sb;
    longint sr;
    logic signed [31:0] t;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = 32'h0;
    c = 1'b0;
    v = 1'b0;
    case (sel)
      4'd0: begin
        r  = a + b;
        c  = (r < a);
        sr = sa + sb;
        v  = (sr != longint'($signed(r)));
      end
      4'd1: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr != longint'($signed(r)));
      end
      4'd3:  r = b;
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd7:  r = a ^ b;
      4'd8:  r = a >> sh;
      4'd9:  r = a << sh;
      4'd10: begin
        t = $signed(a) >>> sh;
        r = t;
      end
      4'd13: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd15: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ec;
    logic        ev;
    int          exp_lat;
    int          lat;
    bit          ready_ok;
    bit          stable;
    logic [31:0] r0;
    logic [3:0]  f0;
    bit          is_sh;
    model(sel, a, b, er, ec, ev);
    is_sh   = (sel == 4'd8) || (sel == 4'd9) || (sel == 4'd10);
    exp_lat = (is_sh && (b[4:0] != 5'd0)) ? 1 + int'(b[4:0]) : 1;
    chk("in_ready_idle", 32'(bif.in_ready), 32'd1);
    bif.in_valid = 1'b1;
    bif.alu_sel  = sel;
    bif.op_a     = a;
    bif.op_b     = b;
    step();
    bif.in_valid = 1'b0;
    bif.op_a     = $urandom;
    bif.op_b     = $urandom;
    lat      = 1;
    ready_ok = 1'b1;
    while (!bif.out_valid && lat < 40) begin
      if (bif.in_ready !== 1'b0) ready_ok = 1'b0;
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("in_ready_low_while_busy", 32'(ready_ok), 32'd1);
    chk("result", bif.result, er);
    chk("flag_zero", 32'(bif.flag_zero), 32'(er == 32'h0));
    chk("flag_carry", 32'(bif.flag_carry), 32'(ec));
    chk("flag_overflow", 32'(bif.flag_overflow), 32'(ev));
    chk("flag_sign", 32'(bif.flag_sign), 32'(er[31]));
    chk("busy_done", 32'(busy), 32'd1);
    r0 = bif.result;
    f0 = {bif.flag_zero, bif.flag_carry, bif.flag_overflow, bif.flag_sign};
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bif.in_valid = 1'b1;
      bif.alu_sel  = 4'($urandom_range(0, 15));
      bif.op_a     = $urandom;
      bif.op_b     = $urandom;
      step();
      if (bif.result !== r0 || {bif.flag_zero, bif.flag_carry, bif.flag_overflow, bif.flag_sign} !== f0 ||
          bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0)
        stable = 1'b0;
    end
    bif.in_valid  = 1'b0;
    chk("hold_stable", 32'(stable), 32'd1);
    bif.out_ready = 1'b1;
    step();
    bif.out_ready = 1'b0;
    chk("drain_out_valid", 32'(bif.out_valid), 32'd0);
    chk("drain_in_ready", 32'(bif.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.alu_sel   = 4'h0;
    bif.op_a      = 32'h0;
    bif.op_b      = 32'h0;
    repeat (3) step();
    chk("rst_result", bif.result, 32'h0);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_flags", 32'({bif.flag_zero, bif.flag_carry, bif.flag_overflow, bif.flag_sign}), 32'd0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();

    run_op(4'd0,  32'h7FFFFFFF, 32'h1, 0);
    run_op(4'd1,  32'd5, 32'd5, 0);
    run_op(4'd1,  32'd0, 32'd1, 0);
    run_op(4'd10, 32'h80000000, 32'd31, 0);
    run_op(4'd9,  32'd1, 32'd0, 0);
    run_op(4'd8,  32'hF0000001, 32'd1, 1);
    run_op(4'd13, 32'hFFFFFFFF, 32'd1, 0);
    run_op(4'd15, 32'hFFFFFFFF, 32'd1, 0);
    run_op(4'd6,  32'h12345678, 32'h9ABCDEF0, 0);
    run_op(4'd0,  32'h00001234, 32'h00004321, 5);

    for (int n = 0; n < 40; n++)
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)));

    // Abort an SRL by 20 partway through.
    bif.in_valid = 1'b1;
    bif.alu_sel  = 4'd8;
    bif.op_a     = 32'hDEADBEEF;
    bif.op_b     = 32'd20;
    step();
    bif.in_valid = 1'b0;
    repeat (7) step();
    chk("midshift_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(bif.out_valid), 32'd0);
    chk("abort_result", bif.result, 32'h0);
    chk("abort_in_ready", 32'(bif.in_ready), 32'd1);
    run_op(4'd0, 32'd100, 32'd23, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
